column_readout_sequencer: RTL

Upstream/downstream companion to the registered column mux in the image-sensor readout path. Per frame, it:
- walks the row address and mux column select across the pixel array;
- captures the mux output one cycle after each select;
- emits a valid/ready pixel stream with frame/line markers to the packetizer.

Credit-based issue means the mux's fixed 1-cycle latency never loses a pixel under backpressure.

---
 rtl/column_readout_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/column_readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : column_readout_sequencer
//  Purpose  : Walks row address and column-mux select across the pixel array,
//             captures the registered mux output one cycle after each select,
//             and streams pixels with sof/eol/eof tags over valid/ready.
//             Two credits (2-entry FIFO plus one in-flight mux slot) keep the
//             1-cycle mux latency lossless under backpressure.
//  Options  : COLUMN_TEST_PATTERN_EN - adds test_mode input; when set at issue
//             time, the captured pixel is (row*MUX_WIDTH + col) instead of
//             mux_data.
//  Revision : 1.0 - initial release
// ============================================================================
module column_readout_sequencer #(
    parameter int MUX_WIDTH = 8,
    parameter int BUS_WIDTH = 8,
    parameter int NUM_ROWS  = 4,
    localparam int c_row_w  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int c_col_w  = $clog2(MUX_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
`ifdef COLUMN_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    output logic                 busy,
    output logic [c_row_w-1:0]   row_addr,
    output logic [c_col_w-1:0]   select,
    input  logic [BUS_WIDTH-1:0] mux_data,
    output logic [BUS_WIDTH-1:0] pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 pix_eof,
    output logic                 frame_done
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(MUX_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(NUM_ROWS - 1);
    localparam logic [c_col_w-1:0] c_col_one  = c_col_w'(1);
    localparam logic [c_row_w-1:0] c_row_one  = c_row_w'(1);

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_frame_done;
    logic [c_row_w-1:0] r_row;        // position of the next column to issue
    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row_hold;   // last issued position, held on the bus
    logic [c_col_w-1:0] r_col_hold;

    // In-flight slot: the pixel currently sitting in the external mux register
    logic               r_inflight;
    logic               r_inf_sof;
    logic               r_inf_eol;
    logic               r_inf_eof;
`ifdef COLUMN_TEST_PATTERN_EN
    logic               r_inf_tp;
    logic [BUS_WIDTH-1:0] r_inf_pat;
`endif

    // Two-entry output FIFO; tag order is {sof, eol, eof}
    logic [BUS_WIDTH-1:0] r_fifo_data [0:1];
    logic [2:0]           r_fifo_tag  [0:1];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [2:0]           w_credits_used;
    logic                 w_issue;
    logic                 w_last_col;
    logic                 w_last_issue;
    logic                 w_fifo_empty;
    logic [BUS_WIDTH-1:0] w_capture;
    logic                 w_xfer;
    logic                 w_write;
    logic                 w_read;
    logic [1:0]           w_count_next;

    assign w_credits_used = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_issue        = (r_state == c_st_issue) && (w_credits_used < 3'd2);
    assign w_last_col     = (r_col == c_col_last);
    assign w_last_issue   = w_last_col && (r_row == c_row_last);
    assign w_fifo_empty   = (r_count == 2'd0);

`ifdef COLUMN_TEST_PATTERN_EN
    logic [BUS_WIDTH-1:0] w_pat;
    assign w_pat     = BUS_WIDTH'(int'(r_row) * MUX_WIDTH + int'(r_col));
    assign w_capture = r_inf_tp ? r_inf_pat : mux_data;
`else
    assign w_capture = mux_data;
`endif

    // Output is the FIFO head; when the FIFO is empty the in-flight pixel is
    // presented directly so a stream with no backpressure runs at one pixel
    // per cycle on just two credits.
    assign pix_valid = !w_fifo_empty || r_inflight;
    assign w_xfer    = pix_valid && pix_ready;

    always_comb begin
        pix_data = '0;
        pix_sof  = 1'b0;
        pix_eol  = 1'b0;
        pix_eof  = 1'b0;
        if (!w_fifo_empty) begin
            pix_data = r_fifo_data[r_rd_ptr];
            {pix_sof, pix_eol, pix_eof} = r_fifo_tag[r_rd_ptr];
        end else if (r_inflight) begin
            pix_data = w_capture;
            {pix_sof, pix_eol, pix_eof} = {r_inf_sof, r_inf_eol, r_inf_eof};
        end
    end

    // An in-flight pixel lands in the FIFO unless it is consumed on the bypass
    assign w_write      = r_inflight && !(w_fifo_empty && w_xfer);
    assign w_read       = w_xfer && !w_fifo_empty;
    assign w_count_next = r_count + {1'b0, w_write} - {1'b0, w_read};

    // Select/row follow the issue immediately, otherwise hold the last issue
    assign select   = w_issue ? r_col : r_col_hold;
    assign row_addr = w_issue ? r_row : r_row_hold;

    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    // ------------------------------------------------------------------
    // Frame sequencer: state, position counters and the in-flight slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_row_hold   <= '0;
            r_col_hold   <= '0;
            r_inflight   <= 1'b0;
            r_inf_sof    <= 1'b0;
            r_inf_eol    <= 1'b0;
            r_inf_eof    <= 1'b0;
`ifdef COLUMN_TEST_PATTERN_EN
            r_inf_tp     <= 1'b0;
            r_inf_pat    <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            r_inflight   <= w_issue;

            if (w_issue) begin
                r_row_hold <= r_row;
                r_col_hold <= r_col;
                r_inf_sof  <= (r_row == '0) && (r_col == '0);
                r_inf_eol  <= w_last_col;
                r_inf_eof  <= w_last_issue;
`ifdef COLUMN_TEST_PATTERN_EN
                r_inf_tp   <= test_mode;
                r_inf_pat  <= w_pat;
`endif
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_issue;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                c_st_issue: begin
                    if (w_issue) begin
                        if (w_last_issue) begin
                            r_state <= c_st_drain;
                        end else if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + c_row_one;
                        end else begin
                            r_col <= r_col + c_col_one;
                        end
                    end
                end
                c_st_drain: begin
                    // Nothing issues in drain, so the pipeline is empty once
                    // the FIFO will be empty: any unconsumed in-flight pixel
                    // would be counted in w_count_next.
                    if (w_count_next == 2'd0) begin
                        r_state      <= c_st_done;
                        r_frame_done <= 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_tag[0]  <= '0;
            r_fifo_tag[1]  <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_write) begin
                r_fifo_data[r_wr_ptr] <= w_capture;
                r_fifo_tag[r_wr_ptr]  <= {r_inf_sof, r_inf_eol, r_inf_eof};
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_read) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
        end
    end

endmodule
`default_nettype wire
